uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous-serial receiver for the board's UART_RXD pin, 8N1 format, LSB first.
- Recovers one byte per frame and presents it with a single-cycle valid strobe.
- Feeds the register-bank write path, so bytes from a host PC can become wd3 data.
- Receive-side counterpart of the serial link.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- CPB (localparam), CLK_FREQ/BAUD using integer division: clocks per bit. Must be ≥ 4, checked at elaboration.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- rst  input  1  asynchronous, active-high reset.
- rxd  input  1  serial line; idles high; asynchronous to clk.
- data  output  8  last correctly received byte.
- valid  output  1  one-cycle pulse; data updated this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values: data=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, synchronizer flops=1.
- rst is asynchronous and active-high. Asserting it mid-frame aborts the frame with no valid or frame_err pulse.
- Input synchronizer: rxd passes through 2 flops to give rxs. All decisions use rxs, which adds 2 clk of latency from the pin.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rxs==0, go to START and clear cnt.
- START: count to CPB/2-1 (mid start bit), then sample rxs.
  - rxs==1: glitch; return to IDLE with no output.
  - rxs==0: go to DATA with bit index=0 and cnt cleared.
- DATA: every CPB clocks sample rxs into shift[index], LSB first. After index 7 is sampled, go to STOP.
- STOP: after CPB clocks, sample rxs.
  - rxs==1: next cycle data<=shift and valid=1; go to IDLE.
  - rxs==0: next cycle frame_err=1, data unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs==1 (break or stuck-low line), then go to IDLE. No further pulses in this state.
- Sample timing, with t0 = cycle rxs first seen low in IDLE:
  - data bit i sampled at t0+CPB/2+(i+1)*CPB.
  - stop bit sampled at t0+CPB/2+9*CPB.
  - valid at stop sample +1.
- No buffering: data holds until the next valid. A consumer that misses the pulse loses nothing until the next frame completes.
- A new start bit is accepted in the first IDLE cycle after valid, so back-to-back frames are received with no gap.
- valid and frame_err are never high together.
- Counter width is $clog2(CPB). Counters never wrap within a bit because they are cleared at every sample.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, WAIT_IDLE).
  - DATA_BITS=8.
  - function cpb(clk_freq, baud).
- One sub-module, uart_sync2: a 2-flop synchronizer with async set to 1 on rst.
- The bit counter and FSM stay in uart_rx.

Test Plan (CLK_FREQ=16, BAUD=1, so CPB=16; the bench drives rxd bit periods of 16 clk):
1. Send 0xA5 with start 0, bits 1,0,1,0,0,1,0,1, stop 1 -> valid high for exactly 1 cycle at t0+153; data=8'hA5; busy high from t0+1 through the valid cycle; frame_err never high.
2. Send 0x00, then 0xFF back-to-back with no idle gap -> two valid pulses 160 clk apart; data=8'h00, then 8'hFF.
3. Pull rxd low for 4 clk, then high -> FSM returns to IDLE at t0+8; no valid, no frame_err; data keeps its previous value.
4. Send 0x3C with stop bit 0, then hold rxd low for 100 clk -> frame_err 1-cycle pulse at t0+153; data unchanged; busy stays high until 2 clk after rxd returns high. The next frame 0x5A is then received correctly.
5. Assert rst during bit 4 of a frame -> outputs go to reset values immediately, with no pulse. After release, a clean 0x81 frame gives valid with data=8'h81.
6. Run at default parameters (CPB=434) with the transmitter bit period at +2% and then -2% error, sending 0x55 and 0xC3 -> both bytes received with valid and correct data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Frame format is 8N1, LSB first.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam int DATA_BITS = 8;

  function automatic int cpb(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle line never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid
// and frame_err strobes, data held until the next good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB = cpb(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  state_t                 state;
  logic                   rxs;
  logic [CW-1:0]          cnt;
  logic [2:0]             idx;
  logic [DATA_BITS-1:0]   shift;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  // busy is held through the valid cycle so a consumer sees
  // the frame as in progress until its byte is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt  <= '0;
          busy <= ~rxs;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            shift[idx] <= rxs;
            if (idx == 3'(DATA_BITS - 1)) state <= STOP;
            else idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rxs) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level timing model checked every cycle,
// plus a default-rate instance driven with +/-2% baud error.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int NEVER = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic rxd2 = 1'b1;
  logic [7:0] data, data2;
  logic valid, frame_err, busy;
  logic valid2, frame_err2, busy2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  uart_rx dut2 (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd2),
    .data      (data2),
    .valid     (valid2),
    .frame_err (frame_err2),
    .busy      (busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         ferr;
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  int         blo[$];
  int         bhi[$];
  logic [7:0] mdata = 8'h00;
  logic [7:0] q2[$];
  int vcyc = -1, pvcyc = -1, fcyc = -1;
  int vcnt = 0, fcnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Pin-to-output timing: a line edge driven at cycle c is seen by
  // the FSM 3 edges later, so a frame's strobe lands at c+155.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      mdata = 8'h00;
      chk("rst_valid", 32'(valid), 32'(0));
      chk("rst_ferr", 32'(frame_err), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_data", 32'(data), 32'(0));
    end else begin
      bit ev, ef, eb;
      ev = 1'b0;
      ef = 1'b0;
      eb = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        if (evq[0].ferr) begin
          ef = 1'b1;
        end else begin
          ev = 1'b1;
          mdata = evq[0].d;
        end
        void'(evq.pop_front());
      end
      foreach (blo[i])
        if (cyc >= blo[i] && cyc <= bhi[i]) eb = 1'b1;
      chk("valid", 32'(valid), 32'(ev));
      chk("frame_err", 32'(frame_err), 32'(ef));
      chk("busy", 32'(busy), 32'(eb));
      chk("data", 32'(data), 32'(mdata));
      chk("d2_ferr", 32'(frame_err2), 32'(0));
      if (valid) begin
        pvcyc = vcyc;
        vcyc = cyc;
        vcnt++;
      end
      if (frame_err) begin
        fcyc = cyc;
        fcnt++;
      end
      if (valid2) q2.push_back(data2);
    end
  end

  task automatic send(input logic [7:0] b, input bit stop, input int hold);
    int c;
    c = cyc;
    blo.push_back(c + 3);
    bhi.push_back(stop ? c + 155 : NEVER);
    evq.push_back('{at: c + 155, ferr: !stop, d: b});
    for (int k = 0; k < 10; k++) begin
      rxd = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
      repeat (CPB) @(negedge clk);
    end
    if (!stop) begin
      repeat (hold) @(negedge clk);
      bhi[bhi.size()-1] = cyc + 2;
      rxd = 1'b1;
    end
  endtask

  task automatic glitch();
    int c;
    c = cyc;
    blo.push_back(c + 3);
    bhi.push_back(c + 10);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic abort_frame(input logic [7:0] b);
    int c;
    c = cyc;
    blo.push_back(c + 3);
    bhi.push_back(NEVER);
    for (int k = 0; k < 5; k++) begin
      rxd = (k == 0) ? 1'b0 : b[k-1];
      repeat (CPB) @(negedge clk);
    end
    rxd = b[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    bhi[bhi.size()-1] = cyc - 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
  endtask

  task automatic slow(input logic [7:0] b, input int per);
    for (int k = 0; k < 10; k++) begin
      rxd2 = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      repeat (per) @(negedge clk);
    end
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    c = cyc;
    send(8'hA5, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("t1_vcyc", 32'(vcyc), 32'(c + 155));
    chk("t1_data", 32'(data), 32'(8'hA5));
    chk("t1_vcnt", 32'(vcnt), 32'(1));

    c = cyc;
    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("t2_vcyc", 32'(vcyc), 32'(c + 315));
    chk("t2_gap", 32'(vcyc - pvcyc), 32'(160));
    chk("t2_data", 32'(data), 32'(8'hFF));
    chk("t2_vcnt", 32'(vcnt), 32'(3));

    repeat (10) @(negedge clk);
    glitch();
    repeat (30) @(negedge clk);
    chk("t3_vcnt", 32'(vcnt), 32'(3));
    chk("t3_fcnt", 32'(fcnt), 32'(0));
    chk("t3_data", 32'(data), 32'(8'hFF));

    c = cyc;
    send(8'h3C, 1'b0, 100);
    repeat (10) @(negedge clk);
    chk("t4_fcyc", 32'(fcyc), 32'(c + 155));
    chk("t4_fcnt", 32'(fcnt), 32'(1));
    chk("t4_data", 32'(data), 32'(8'hFF));
    chk("t4_busy", 32'(busy), 32'(0));
    c = cyc;
    send(8'h5A, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("t4_vcyc", 32'(vcyc), 32'(c + 155));
    chk("t4_data2", 32'(data), 32'(8'h5A));

    repeat (10) @(negedge clk);
    abort_frame(8'hF0);
    repeat (10) @(negedge clk);
    chk("t5_data_rst", 32'(data), 32'(8'h00));
    chk("t5_vcnt", 32'(vcnt), 32'(4));
    c = cyc;
    send(8'h81, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("t5_vcyc", 32'(vcyc), 32'(c + 155));
    chk("t5_data", 32'(data), 32'(8'h81));

    slow(8'h55, 443);
    repeat (2) @(negedge clk);
    chk("t6_cnt_fast", 32'(q2.size()), 32'(1));
    if (q2.size() > 0) chk("t6_data_fast", 32'(q2[0]), 32'(8'h55));
    slow(8'hC3, 425);
    repeat (20) @(negedge clk);
    chk("t6_cnt_slow", 32'(q2.size()), 32'(2));
    if (q2.size() > 1) chk("t6_data_slow", 32'(q2[1]), 32'(8'hC3));
    chk("t6_busy", 32'(busy2), 32'(0));
    chk("t6_data2", 32'(data2), 32'(8'hC3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
